// File: rtl/z80_bus_bridge_fifo_if.sv
// Z80 bus / GPU RAM signal bundle for the Z80-to-GPU-RAM bridge.
// gpu_rd_req is a one-clock request; the mux answers with a one-clock gpu_rd_rdy while gpu_rData is valid.
interface z80_bus_bridge_fifo_if #(
  parameter int GPU_ADDR_W  = 20,
  parameter int WFIFO_DEPTH = 4
);
  localparam int LW = $clog2(WFIFO_DEPTH) + 1;

  logic                  Z80_CLK;
  logic                  Z80_M1n;
  logic                  Z80_MREQn;
  logic                  Z80_WRn;
  logic                  Z80_RDn;
  logic [21:0]           Z80_addr;
  logic [7:0]            Z80_wData;
  logic [7:0]            gpu_rData;
  logic                  gpu_rd_rdy;
  logic                  Z80_245data_dir;
  logic                  Z80_245_oe;
  logic [7:0]            Z80_rData;
  logic                  Z80_rData_ena;
  logic                  Z80_WAITn;
  logic                  gpu_wr_ena;
  logic                  gpu_rd_req;
  logic [GPU_ADDR_W-1:0] gpu_addr;
  logic [7:0]            gpu_wdata;
  logic [LW-1:0]         wfifo_level;
  logic                  wr_overflow;
  logic                  rd_timeout;
  logic [2:0]            dbg_state;
  logic                  dbg_z80_clk_rise;

  modport slave (
    input  Z80_CLK, Z80_M1n, Z80_MREQn, Z80_WRn, Z80_RDn, Z80_addr, Z80_wData,
    input  gpu_rData, gpu_rd_rdy,
    output Z80_245data_dir, Z80_245_oe, Z80_rData, Z80_rData_ena, Z80_WAITn,
    output gpu_wr_ena, gpu_rd_req, gpu_addr, gpu_wdata,
    output wfifo_level, wr_overflow, rd_timeout, dbg_state, dbg_z80_clk_rise
  );

  modport master (
    output Z80_CLK, Z80_M1n, Z80_MREQn, Z80_WRn, Z80_RDn, Z80_addr, Z80_wData,
    output gpu_rData, gpu_rd_rdy,
    input  Z80_245data_dir, Z80_245_oe, Z80_rData, Z80_rData_ena, Z80_WAITn,
    input  gpu_wr_ena, gpu_rd_req, gpu_addr, gpu_wdata,
    input  wfifo_level, wr_overflow, rd_timeout, dbg_state, dbg_z80_clk_rise
  );
endinterface

// File: rtl/z80_bus_bridge_fifo.sv
// Z80-to-GPU-RAM bridge: synchronised Z80 decode, posted write FIFO draining one entry per clock,
// and a read FSM that flushes the FIFO before a req/rdy handshake with WAIT insertion and timeout.
module z80_bus_bridge_fifo #(
  parameter logic [2:0] MEMORY_RANGE = 3'b011,
  parameter int GPU_ADDR_W   = 20,
  parameter int SYNC_STAGES  = 2,
  parameter int DELAY_CYCLES = 2,
  parameter int WFIFO_DEPTH  = 4,
  parameter int RD_TIMEOUT   = 255,
  parameter int WAIT_ENABLE  = 1
) (
  input logic GPU_CLK,
  input logic reset,
  z80_bus_bridge_fifo_if.slave bus
);
  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    TO_LIM   = 8'(RD_TIMEOUT);
  localparam logic [7:0]    DLY      = 8'(DELAY_CYCLES);
  localparam logic [LW-1:0] FULL_LVL = LW'(WFIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_DRAIN = 3'd1,
    RD_REQ   = 3'd2,
    RD_WAIT  = 3'd3,
    RD_HOLD  = 3'd4
  } state_t;

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;
  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [SYNC_STAGES-1:0] mreq_sr, m1_sr, wr_sr, rd_sr, zclk_sr;
  logic wr_q, rd_q, zclk_q;
  always_ff @(posedge GPU_CLK or negedge rst_n) begin
    if (!rst_n) begin
      mreq_sr <= '1;
      m1_sr   <= '1;
      wr_sr   <= '1;
      rd_sr   <= '1;
      zclk_sr <= '0;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      zclk_q  <= 1'b0;
    end else begin
      mreq_sr <= {mreq_sr[SYNC_STAGES-2:0], bus.Z80_MREQn};
      m1_sr   <= {m1_sr[SYNC_STAGES-2:0],   bus.Z80_M1n};
      wr_sr   <= {wr_sr[SYNC_STAGES-2:0],   bus.Z80_WRn};
      rd_sr   <= {rd_sr[SYNC_STAGES-2:0],   bus.Z80_RDn};
      zclk_sr <= {zclk_sr[SYNC_STAGES-2:0], bus.Z80_CLK};
      wr_q    <= wr_sr[SYNC_STAGES-1];
      rd_q    <= rd_sr[SYNC_STAGES-1];
      zclk_q  <= zclk_sr[SYNC_STAGES-1];
    end
  end

  logic mreq_s, m1_s, wr_s, rd_s, zclk_s;
  assign mreq_s = mreq_sr[SYNC_STAGES-1];
  assign m1_s   = m1_sr[SYNC_STAGES-1];
  assign wr_s   = wr_sr[SYNC_STAGES-1];
  assign rd_s   = rd_sr[SYNC_STAGES-1];
  assign zclk_s = zclk_sr[SYNC_STAGES-1];

  logic hit, wr_fall, rd_fall, rd_rise;
  assign hit     = (bus.Z80_addr[21:19] == MEMORY_RANGE) & ~mreq_s & m1_s;
  assign wr_fall = wr_q & ~wr_s;
  assign rd_fall = rd_q & ~rd_s;
  assign rd_rise = ~rd_q & rd_s;
  assign bus.dbg_z80_clk_rise = ~zclk_q & zclk_s;

  state_t state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [26:0]   mem [WFIFO_DEPTH];
  logic          fifo_empty, fifo_full;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);

  // The edge clock counts as the first delay clock, so the bus is sampled DELAY_CYCLES clocks after the synced edge.
  logic       wr_pend, wr_trig, wr_go, wr_push, push_ok, pop;
  logic [7:0] wr_cnt, wr_elapsed;
  assign wr_trig    = wr_fall & hit & ~wr_pend;
  assign wr_go      = wr_trig | wr_pend;
  assign wr_elapsed = wr_pend ? wr_cnt + 8'd1 : 8'd1;
  assign wr_push    = wr_go & (wr_elapsed >= DLY);
  assign push_ok    = wr_push & ~fifo_full;
  assign pop        = ~fifo_empty & (state != RD_REQ) & (state != RD_WAIT);

  logic       rd_pend, rd_trig, rd_go, rd_latch, rd_abort, issue_req;
  logic [7:0] rd_cnt, rd_elapsed;
  logic [18:0] rd_addr;
  assign rd_trig    = rd_fall & hit & (state == IDLE) & ~rd_pend;
  assign rd_go      = rd_trig | rd_pend;
  assign rd_elapsed = rd_pend ? rd_cnt + 8'd1 : 8'd1;
  assign rd_latch   = rd_go & (rd_elapsed >= DLY);
  assign rd_abort   = rd_rise & ((state != IDLE) | rd_pend);
  assign issue_req  = (state == RD_DRAIN) & fifo_empty & ~rd_abort;

  always_ff @(posedge GPU_CLK) begin
    if (push_ok) mem[wr_ptr] <= {bus.Z80_addr[18:0], bus.Z80_wData};
  end

  logic                  wr_overflow_q, gpu_wr_ena_q, gpu_rd_req_q;
  logic [GPU_ADDR_W-1:0] gpu_addr_q;
  logic [7:0]            gpu_wdata_q;
  always_ff @(posedge GPU_CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend       <= 1'b0;
      wr_cnt        <= 8'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      wr_overflow_q <= 1'b0;
      gpu_wr_ena_q  <= 1'b0;
      gpu_rd_req_q  <= 1'b0;
      gpu_addr_q    <= '0;
      gpu_wdata_q   <= 8'd0;
    end else begin
      if (wr_push) begin
        wr_pend <= 1'b0;
      end else if (wr_go) begin
        wr_pend <= 1'b1;
        wr_cnt  <= wr_elapsed;
      end
      if (push_ok)            wr_ptr        <= wr_ptr + 1'b1;
      if (wr_push & fifo_full) wr_overflow_q <= 1'b1;
      if (pop)                rd_ptr        <= rd_ptr + 1'b1;
      level        <= level + LW'(push_ok) - LW'(pop);
      gpu_wr_ena_q <= pop;
      gpu_rd_req_q <= issue_req;
      if (pop) begin
        gpu_addr_q  <= GPU_ADDR_W'(mem[rd_ptr][26:8]);
        gpu_wdata_q <= mem[rd_ptr][7:0];
      end else if (issue_req) begin
        gpu_addr_q  <= GPU_ADDR_W'(rd_addr);
      end
    end
  end

  logic [7:0] timer, rdata_q;
  logic       rdata_ena_q, waitn_q, rd_active, rd_timeout_q;
  always_ff @(posedge GPU_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_pend      <= 1'b0;
      rd_cnt       <= 8'd0;
      rd_addr      <= '0;
      timer        <= 8'd0;
      rdata_q      <= 8'd0;
      rdata_ena_q  <= 1'b0;
      waitn_q      <= 1'b1;
      rd_active    <= 1'b0;
      rd_timeout_q <= 1'b0;
    end else if (rd_abort) begin
      // RD_HOLD's normal exit and a premature RDn release both land here.
      state       <= IDLE;
      rd_pend     <= 1'b0;
      rd_active   <= 1'b0;
      rdata_ena_q <= 1'b0;
      waitn_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_trig) begin
            rd_active <= 1'b1;
            waitn_q   <= (WAIT_ENABLE == 0);
          end
          if (rd_latch) begin
            rd_pend <= 1'b0;
            rd_addr <= bus.Z80_addr[18:0];
            state   <= RD_DRAIN;
          end else if (rd_go) begin
            rd_pend <= 1'b1;
            rd_cnt  <= rd_elapsed;
          end
        end
        RD_DRAIN: if (fifo_empty) state <= RD_REQ;
        RD_REQ: begin
          timer <= 8'd0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.gpu_rd_rdy) begin
            rdata_q     <= bus.gpu_rData;
            rdata_ena_q <= 1'b1;
            waitn_q     <= 1'b1;
            state       <= RD_HOLD;
          end else if (timer == TO_LIM) begin
            rdata_q      <= 8'hFF;
            rd_timeout_q <= 1'b1;
            rdata_ena_q  <= 1'b1;
            waitn_q      <= 1'b1;
            state        <= RD_HOLD;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RD_HOLD: state <= RD_HOLD;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Z80_245data_dir = ~rd_active;
  assign bus.Z80_245_oe      = rd_active | wr_pend;
  assign bus.Z80_rData       = rdata_q;
  assign bus.Z80_rData_ena   = rdata_ena_q;
  assign bus.Z80_WAITn       = waitn_q;
  assign bus.gpu_wr_ena      = gpu_wr_ena_q;
  assign bus.gpu_rd_req      = gpu_rd_req_q;
  assign bus.gpu_addr        = gpu_addr_q;
  assign bus.gpu_wdata       = gpu_wdata_q;
  assign bus.wfifo_level     = level;
  assign bus.wr_overflow     = wr_overflow_q;
  assign bus.rd_timeout      = rd_timeout_q;
  assign bus.dbg_state       = state;
endmodule

// File: tb/tb_z80_bus_bridge_fifo.sv
// Directed bench for z80_bus_bridge_fifo: write posting, read handshake, ordering, overflow, timeout, reset.
module tb_z80_bus_bridge_fifo;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  z80_bus_bridge_fifo_if #(.GPU_ADDR_W(20), .WFIFO_DEPTH(4)) bus ();

  z80_bus_bridge_fifo #(
    .MEMORY_RANGE(3'b011), .GPU_ADDR_W(20), .SYNC_STAGES(2), .DELAY_CYCLES(2),
    .WFIFO_DEPTH(4), .RD_TIMEOUT(255), .WAIT_ENABLE(1)
  ) dut (
    .GPU_CLK(clk),
    .reset  (rst_n),
    .bus    (bus.slave)
  );

  // clock/reset
  always #4 clk = ~clk;
  initial begin
    bus.Z80_CLK = 1'b0;
    forever #62 bus.Z80_CLK = ~bus.Z80_CLK;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: expected GPU writes {addr, data} in order
  logic [27:0] exp_q[$];
  int          wr_seen     = 0;
  int          rd_req_seen = 0;
  always @(negedge clk) begin
    if (bus.gpu_wr_ena === 1'b1) begin
      logic [27:0] got, e;
      got = {bus.gpu_addr, bus.gpu_wdata};
      wr_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_write: observed=%0h expected=none", got);
      end else begin
        e = exp_q.pop_front();
        assert (got === e) else begin
          bad++;
          $error("FAIL write_order: observed=%0h expected=%0h", got, e);
        end
      end
    end
    if (bus.gpu_rd_req === 1'b1) rd_req_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic z80_write(input logic [21:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.Z80_addr = a; bus.Z80_wData = d; bus.Z80_MREQn = 1'b0; bus.Z80_WRn = 1'b0;
    repeat (5) @(negedge clk);
    bus.Z80_WRn = 1'b1; bus.Z80_MREQn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_read(input logic [21:0] a);
    @(negedge clk);
    bus.Z80_addr = a; bus.Z80_MREQn = 1'b0; bus.Z80_RDn = 1'b0;
  endtask

  task automatic end_read();
    @(negedge clk);
    bus.Z80_RDn = 1'b1; bus.Z80_MREQn = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.gpu_rd_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.gpu_rd_req), 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int n = 0;
    while (bus.dbg_state !== s && n < 200) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.dbg_state), 32'(s));
  endtask

  initial begin
    int base_wr, base_req, n;
    rst_n = 1'b0;
    bus.Z80_M1n = 1'b1; bus.Z80_MREQn = 1'b1; bus.Z80_WRn = 1'b1; bus.Z80_RDn = 1'b1;
    bus.Z80_addr = 22'd0; bus.Z80_wData = 8'd0; bus.gpu_rData = 8'd0; bus.gpu_rd_rdy = 1'b0;

    // reset values
    #5;
    chk("rst_waitn", 32'(bus.Z80_WAITn), 32'd1);
    chk("rst_dir",   32'(bus.Z80_245data_dir), 32'd1);
    chk("rst_oe",    32'(bus.Z80_245_oe), 32'd0);
    chk("rst_strobes", 32'({bus.gpu_wr_ena, bus.gpu_rd_req, bus.Z80_rData_ena}), 32'd0);
    chk("rst_level", 32'(bus.wfifo_level), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: write 0xA5 to 0x180010; synced edge after 2 clocks, push 2 clocks later, strobe the next clock
    exp_q.push_back({20'h00010, 8'hA5});
    @(negedge clk);
    bus.Z80_addr = 22'h180010; bus.Z80_wData = 8'hA5; bus.Z80_MREQn = 1'b0; bus.Z80_WRn = 1'b0;
    repeat (3) @(negedge clk);
    chk("wr_oe_during", 32'(bus.Z80_245_oe), 32'd1);
    chk("wr_dir_during", 32'(bus.Z80_245data_dir), 32'd1);
    chk("wr_rdata_ena", 32'(bus.Z80_rData_ena), 32'd0);
    @(negedge clk);
    chk("wr_level_after_push", 32'(bus.wfifo_level), 32'd1);
    chk("wr_no_strobe_yet", 32'(bus.gpu_wr_ena), 32'd0);
    @(negedge clk);
    chk("wr_strobe", 32'(bus.gpu_wr_ena), 32'd1);
    chk("wr_addr", 32'(bus.gpu_addr), 32'h00010);
    chk("wr_data", 32'(bus.gpu_wdata), 32'hA5);
    @(negedge clk);
    chk("wr_strobe_one_clk", 32'(bus.gpu_wr_ena), 32'd0);
    bus.Z80_WRn = 1'b1; bus.Z80_MREQn = 1'b1;
    repeat (4) @(negedge clk);

    // 2: read 0x1FFFFF, mux rdy three clocks after the request
    base_req = rd_req_seen;
    start_read(22'h1FFFFF);
    wait_req("rd_req_seen");
    chk("rd_req_addr", 32'(bus.gpu_addr), 32'h7FFFF);
    chk("rd_waitn_low", 32'(bus.Z80_WAITn), 32'd0);
    chk("rd_dir_toward_z80", 32'(bus.Z80_245data_dir), 32'd0);
    repeat (2) @(negedge clk);
    chk("rd_waitn_still_low", 32'(bus.Z80_WAITn), 32'd0);
    bus.gpu_rd_rdy = 1'b1; bus.gpu_rData = 8'h3C;
    @(negedge clk);
    bus.gpu_rd_rdy = 1'b0; bus.gpu_rData = 8'h00;
    chk("rd_data", 32'(bus.Z80_rData), 32'h3C);
    chk("rd_data_ena", 32'(bus.Z80_rData_ena), 32'd1);
    chk("rd_waitn_released", 32'(bus.Z80_WAITn), 32'd1);
    chk("rd_oe_hold", 32'(bus.Z80_245_oe), 32'd1);
    end_read();
    repeat (6) @(negedge clk);
    chk("rd_oe_off", 32'(bus.Z80_245_oe), 32'd0);
    chk("rd_ena_off", 32'(bus.Z80_rData_ena), 32'd0);
    chk("rd_dir_back", 32'(bus.Z80_245data_dir), 32'd1);
    chk("rd_single_req", 32'(rd_req_seen - base_req), 32'd1);

    // 3: three writes then read-after-write of the last address
    base_wr = wr_seen;
    exp_q.push_back({20'h00020, 8'h11}); z80_write(22'h180020, 8'h11);
    exp_q.push_back({20'h00021, 8'h22}); z80_write(22'h180021, 8'h22);
    exp_q.push_back({20'h00022, 8'h33}); z80_write(22'h180022, 8'h33);
    start_read(22'h180022);
    wait_req("raw_req_seen");
    chk("raw_level_at_req", 32'(bus.wfifo_level), 32'd0);
    chk("raw_writes_before_req", 32'(wr_seen - base_wr), 32'd3);
    chk("raw_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("raw_req_addr", 32'(bus.gpu_addr), 32'h00022);
    @(negedge clk);
    bus.gpu_rd_rdy = 1'b1; bus.gpu_rData = 8'h33;
    @(negedge clk);
    bus.gpu_rd_rdy = 1'b0;
    chk("raw_rdata", 32'(bus.Z80_rData), 32'h33);
    end_read();
    repeat (6) @(negedge clk);

    // 4: drain blocked by a read in RD_WAIT; five writes overflow a 4-deep FIFO
    start_read(22'h180200);
    wait_state("ovf_in_rd_wait", 3'd3);
    base_wr = wr_seen;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({20'h00100 + 20'(i), 8'hC0 + 8'(i)});
      z80_write(22'h180100 + 22'(i), 8'hC0 + 8'(i));
    end
    chk("ovf_level", 32'(bus.wfifo_level), 32'd4);
    chk("ovf_flag", 32'(bus.wr_overflow), 32'd1);
    chk("ovf_no_drain", 32'(wr_seen - base_wr), 32'd0);
    chk("ovf_still_waiting", 32'(bus.dbg_state), 32'd3);
    end_read();
    repeat (12) @(negedge clk);
    chk("ovf_drained_four", 32'(wr_seen - base_wr), 32'd4);
    chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ovf_flag_sticky", 32'(bus.wr_overflow), 32'd1);
    chk("ovf_no_timeout", 32'(bus.rd_timeout), 32'd0);

    // 5: read with no rdy; abort with 0xFF after RD_TIMEOUT clocks in RD_WAIT
    start_read(22'h180300);
    wait_req("to_req_seen");
    n = 0;
    while (bus.Z80_rData_ena !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk("to_latency_window", 32'((n >= 255) && (n <= 260)), 32'd1);
    chk("to_rdata", 32'(bus.Z80_rData), 32'hFF);
    chk("to_flag", 32'(bus.rd_timeout), 32'd1);
    chk("to_waitn", 32'(bus.Z80_WAITn), 32'd1);
    end_read();
    repeat (6) @(negedge clk);
    chk("to_idle", 32'(bus.dbg_state), 32'd0);

    // 6: out-of-window write, then reset mid-RD_WAIT with an entry stuck in the FIFO
    base_wr = wr_seen;
    z80_write(22'h080000, 8'h5A);
    repeat (4) @(negedge clk);
    chk("miss_no_strobe", 32'(wr_seen - base_wr), 32'd0);
    chk("miss_level", 32'(bus.wfifo_level), 32'd0);
    start_read(22'h180400);
    wait_state("rst_in_rd_wait", 3'd3);
    z80_write(22'h180040, 8'h77);
    chk("rst_pending_entry", 32'(bus.wfifo_level), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_waitn", 32'(bus.Z80_WAITn), 32'd1);
    chk("mid_rst_dir", 32'(bus.Z80_245data_dir), 32'd1);
    chk("mid_rst_oe", 32'(bus.Z80_245_oe), 32'd0);
    chk("mid_rst_rdata", 32'({bus.Z80_rData_ena, bus.Z80_rData}), 32'd0);
    chk("mid_rst_gpu", 32'({bus.gpu_wr_ena, bus.gpu_rd_req, bus.gpu_addr}), 32'd0);
    chk("mid_rst_flags", 32'({bus.wr_overflow, bus.rd_timeout}), 32'd0);
    chk("mid_rst_level", 32'(bus.wfifo_level), 32'd0);
    chk("mid_rst_state", 32'(bus.dbg_state), 32'd0);
    bus.Z80_RDn = 1'b1; bus.Z80_MREQn = 1'b1; bus.Z80_WRn = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_level", 32'(bus.wfifo_level), 32'd0);
    chk("post_rst_no_strobe", 32'(wr_seen - base_wr), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
